// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencing controller: Moore FSM stepping fetch/decode/execute/memory/writeback
// with embedded ALU-control decode and a memory-ready stall handshake.
module multicycle_control_fsm #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECR    = STATE_W'(6),
    EXECI    = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BEQ      = STATE_W'(9),
    JAL      = STATE_W'(10),
    TRAP     = STATE_W'(11)
  } state_t;

  typedef struct packed {
    logic       pcupdate;
    logic       branch;
    logic       irwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       regwrite;
    logic       done;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic [1:0] aluop;
  } ctrl_t;

  state_t state;
  state_t nxt;
  ctrl_t  ctrl;
  logic   illegal_r;

  // Moore control word of a state; op5 only matters for the MEMADR immediate format.
  function automatic ctrl_t ctrl_of(input state_t s, input logic op5);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
        c.pcupdate  = 1'b1;
        c.irwrite   = 1'b1;
      end
      DECODE: begin
        c.alusrca = 2'b01;
        c.alusrcb = 2'b01;
        c.immsrc  = 2'b10;
      end
      MEMADR: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.immsrc  = op5 ? 2'b01 : 2'b00;
      end
      MEMREAD: c.adrsrc = 1'b1;
      MEMWB: begin
        c.resultsrc = 2'b01;
        c.regwrite  = 1'b1;
        c.done      = 1'b1;
      end
      MEMWRITE: begin
        c.adrsrc   = 1'b1;
        c.memwrite = 1'b1;
      end
      EXECR: begin
        c.alusrca = 2'b10;
        c.aluop   = 2'b10;
      end
      EXECI: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = 2'b10;
      end
      ALUWB: begin
        c.regwrite = 1'b1;
        c.done     = 1'b1;
      end
      BEQ: begin
        c.alusrca = 2'b10;
        c.aluop   = 2'b01;
        c.branch  = 1'b1;
        c.done    = 1'b1;
      end
      JAL: begin
        c.alusrca  = 2'b01;
        c.alusrcb  = 2'b10;
        c.pcupdate = 1'b1;
        c.immsrc   = 2'b11;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      FETCH:    nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: nxt = MEMADR;
          7'b0110011:             nxt = EXECR;
          7'b0010011:             nxt = EXECI;
          7'b1100011:             nxt = BEQ;
          7'b1101111:             nxt = JAL;
          default:                nxt = TRAP;
        endcase
      end
      MEMADR:   nxt = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    nxt = FETCH;
      MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
      EXECR:    nxt = ALUWB;
      EXECI:    nxt = ALUWB;
      ALUWB:    nxt = FETCH;
      BEQ:      nxt = FETCH;
      JAL:      nxt = ALUWB;
      TRAP:     nxt = TRAP;
      default:  nxt = FETCH;
    endcase
  end

  // Control word is registered from the next state so it lines up with the state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= FETCH;
      ctrl      <= ctrl_of(FETCH, 1'b0);
      illegal_r <= 1'b0;
    end else begin
      state     <= nxt;
      ctrl      <= ctrl_of(nxt, op[5]);
      illegal_r <= illegal_r | (nxt == TRAP);
    end
  end

  always_comb begin
    ALUControl = 3'b000;
    case (ctrl.aluop)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Input-qualified strobes: FETCH waits on mem_ready, BEQ on Zero, MEMWRITE finishes on mem_ready.
  assign PCWrite    = rst & ((ctrl.pcupdate & (~ctrl.irwrite | mem_ready)) | (ctrl.branch & Zero));
  assign IRWrite    = rst & ctrl.irwrite & mem_ready;
  assign RegWrite   = rst & ctrl.regwrite;
  assign MemWrite   = rst & ctrl.memwrite;
  assign instr_done = rst & (ctrl.done | (ctrl.memwrite & mem_ready));
  assign AdrSrc     = ctrl.adrsrc;
  assign ResultSrc  = ctrl.resultsrc;
  assign ALUSrcA    = ctrl.alusrca;
  assign ALUSrcB    = ctrl.alusrcb;
  assign ImmSrc     = ctrl.immsrc;
  assign illegal    = illegal_r;
  assign state_o    = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: table of instructions plus hand sequences for stalls, reset and trap,
// checked cycle by cycle against a behavioural model through a scoreboard queue.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       instr_done, illegal;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .instr_done(instr_done),
    .illegal(illegal), .state_o(state_o)
  );

  typedef enum logic [3:0] {
    M_FETCH, M_DECODE, M_MEMADR, M_MEMREAD, M_MEMWB, M_MEMWRITE,
    M_EXECR, M_EXECI, M_ALUWB, M_BEQ, M_JAL, M_TRAP
  } mst_t;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, a, b, imm;
    logic [2:0] alu;
    logic       done, ill;
  } obs_t;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    int unsigned stall;
    int unsigned lat;
    logic        chk_alu;
    logic [2:0]  alu;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  mst_t mst;
  logic mill;
  obs_t sb[$];
  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic obs_t model(input mst_t s, input logic ill, input logic rstn, input logic [6:0] o,
                                 input logic [2:0] f3, input logic f7, input logic z, input logic mr);
    obs_t e;
    logic [1:0] aluop;
    e = '0;
    aluop = 2'b00;
    e.st = s;
    e.ill = ill;
    case (s)
      M_FETCH:    begin e.b = 2'b10; e.rs = 2'b10; e.pcw = mr; e.irw = mr; end
      M_DECODE:   begin e.a = 2'b01; e.b = 2'b01; e.imm = 2'b10; end
      M_MEMADR:   begin e.a = 2'b10; e.b = 2'b01; e.imm = o[5] ? 2'b01 : 2'b00; end
      M_MEMREAD:  e.adr = 1'b1;
      M_MEMWB:    begin e.rs = 2'b01; e.rw = 1'b1; e.done = 1'b1; end
      M_MEMWRITE: begin e.adr = 1'b1; e.mw = 1'b1; e.done = mr; end
      M_EXECR:    begin e.a = 2'b10; aluop = 2'b10; end
      M_EXECI:    begin e.a = 2'b10; e.b = 2'b01; aluop = 2'b10; end
      M_ALUWB:    begin e.rw = 1'b1; e.done = 1'b1; end
      M_BEQ:      begin e.a = 2'b10; aluop = 2'b01; e.pcw = z; e.done = 1'b1; end
      M_JAL:      begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1; e.imm = 2'b11; end
      default:    ;
    endcase
    if (aluop == 2'b01) e.alu = 3'b001;
    else if (aluop == 2'b10) begin
      if (f3 == 3'b000)      e.alu = (o[5] && f7) ? 3'b001 : 3'b000;
      else if (f3 == 3'b010) e.alu = 3'b101;
      else if (f3 == 3'b110) e.alu = 3'b011;
      else if (f3 == 3'b111) e.alu = 3'b010;
    end
    if (!rstn) begin e.pcw = 0; e.irw = 0; e.rw = 0; e.mw = 0; e.done = 0; end
    return e;
  endfunction

  function automatic mst_t model_next(input mst_t s, input logic [6:0] o, input logic mr);
    case (s)
      M_FETCH:    return mr ? M_DECODE : M_FETCH;
      M_DECODE:
        if (o == 7'b0000011 || o == 7'b0100011) return M_MEMADR;
        else if (o == 7'b0110011) return M_EXECR;
        else if (o == 7'b0010011) return M_EXECI;
        else if (o == 7'b1100011) return M_BEQ;
        else if (o == 7'b1101111) return M_JAL;
        else return M_TRAP;
      M_MEMADR:   return o[5] ? M_MEMWRITE : M_MEMREAD;
      M_MEMREAD:  return mr ? M_MEMWB : M_MEMREAD;
      M_MEMWRITE: return mr ? M_FETCH : M_MEMWRITE;
      M_EXECR, M_EXECI, M_JAL: return M_ALUWB;
      M_TRAP:     return M_TRAP;
      default:    return M_FETCH;
    endcase
  endfunction

  // One clock: expectation queued from the driven inputs, compared against the DUT at the negedge.
  task automatic tick(input string name, output obs_t g);
    obs_t e;
    mst_t n;
    @(negedge clk);
    sb.push_back(model(mst, mill, rst, op, funct3, funct7, Zero, mem_ready));
    g.st = state_o; g.pcw = PCWrite; g.adr = AdrSrc; g.mw = MemWrite; g.irw = IRWrite;
    g.rw = RegWrite; g.rs = ResultSrc; g.a = ALUSrcA; g.b = ALUSrcB; g.imm = ImmSrc;
    g.alu = ALUControl; g.done = instr_done; g.ill = illegal;
    e = sb.pop_front();
    check(name, 32'(g), 32'(e));
    n = model_next(mst, op, mem_ready);
    @(posedge clk);
    if (!rst) begin mst = M_FETCH; mill = 1'b0; end
    else begin mill = mill | (n == M_TRAP); mst = n; end
    #1;
  endtask

  task automatic run_instr(input vec_t v);
    obs_t g;
    int unsigned stalls = 0;
    int unsigned dut_lat = 0;
    logic [2:0] alu_got = 3'b111;
    logic fin = 1'b0;
    op = v.op; funct3 = v.f3; funct7 = v.f7; Zero = v.z;
    for (int c = 1; c <= 20 && !fin; c++) begin
      if (mst == M_MEMREAD || mst == M_MEMWRITE) begin
        mem_ready = (stalls >= v.stall);
        if (stalls < v.stall) stalls++;
      end else mem_ready = 1'b1;
      if (mst == M_EXECR || mst == M_EXECI) begin
        tick(v.name, g);
        alu_got = g.alu;
      end else tick(v.name, g);
      if (g.done && dut_lat == 0) dut_lat = c;
      if (mst == M_FETCH) fin = 1'b1;
    end
    check({v.name, "_latency"}, dut_lat, v.lat);
    if (v.chk_alu) check({v.name, "_alu"}, 32'(alu_got), 32'(v.alu));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t g;
    vt[0]  = '{"lw",       7'b0000011, 3'b010, 1'b0, 1'b0, 0, 5, 1'b0, 3'b000};
    vt[1]  = '{"lw_stall", 7'b0000011, 3'b010, 1'b0, 1'b0, 3, 8, 1'b0, 3'b000};
    vt[2]  = '{"sw_stall", 7'b0100011, 3'b010, 1'b0, 1'b0, 2, 6, 1'b0, 3'b000};
    vt[3]  = '{"r_sub",    7'b0110011, 3'b000, 1'b1, 1'b0, 0, 4, 1'b1, 3'b001};
    vt[4]  = '{"r_add",    7'b0110011, 3'b000, 1'b0, 1'b0, 0, 4, 1'b1, 3'b000};
    vt[5]  = '{"r_slt",    7'b0110011, 3'b010, 1'b0, 1'b0, 0, 4, 1'b1, 3'b101};
    vt[6]  = '{"r_and",    7'b0110011, 3'b111, 1'b0, 1'b0, 0, 4, 1'b1, 3'b010};
    vt[7]  = '{"r_or",     7'b0110011, 3'b110, 1'b0, 1'b0, 0, 4, 1'b1, 3'b011};
    vt[8]  = '{"i_addi",   7'b0010011, 3'b000, 1'b1, 1'b0, 0, 4, 1'b1, 3'b000};
    vt[9]  = '{"beq_z1",   7'b1100011, 3'b000, 1'b0, 1'b1, 0, 3, 1'b0, 3'b000};
    vt[10] = '{"beq_z0",   7'b1100011, 3'b000, 1'b0, 1'b0, 0, 3, 1'b0, 3'b000};
    vt[11] = '{"jal",      7'b1101111, 3'b000, 1'b0, 1'b0, 0, 4, 1'b0, 3'b000};

    rst = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
    mst = M_FETCH; mill = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    tick("reset_hold", g);
    check("reset_enables", {g.st, g.pcw, g.irw, g.rw, g.mw, g.done}, '0);

    rst = 1'b1;
    tick("fetch_after_reset", g);
    check("fetch_after_reset_sel", {g.irw, g.pcw, g.b, g.rs}, 6'b111010);
    for (int i = 0; i < 3; i++) tick("r_after_reset", g);

    foreach (vt[i]) run_instr(vt[i]);

    mem_ready = 1'b0; op = 7'b0110011;
    for (int i = 0; i < 3; i++) begin
      tick("fetch_stall", g);
      check("fetch_stall_strobes", {g.irw, g.pcw, g.st}, '0);
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick("after_fetch_stall", g);

    tick("mid_rst_fetch", g);
    tick("mid_rst_decode", g);
    rst = 1'b0;
    tick("mid_rst_exec", g);
    check("mid_rst_strobes", {g.pcw, g.irw, g.rw, g.mw, g.done}, '0);
    rst = 1'b1;
    run_instr(vt[3]);

    op = 7'b1111111;
    tick("trap_fetch", g);
    tick("trap_decode", g);
    for (int i = 0; i < 10; i++) begin
      tick("trap_hold", g);
      check("trap_sticky", {g.st, g.ill, g.pcw, g.irw, g.rw, g.mw, g.done}, {4'd11, 6'b100000});
    end
    rst = 1'b0;
    tick("trap_reset", g);
    rst = 1'b1;
    op = 7'b0110011;
    tick("trap_cleared", g);
    check("trap_cleared_state", {g.st, g.ill}, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Sequencing controller for the multi-cycle variant of the RV32I core. It replaces the single-cycle control path with a Moore FSM that steps one instruction through fetch, decode, execute, memory and writeback over 3-5 cycles, reusing one ALU and one unified memory port. It embeds the ALU-control decode and stalls on a memory ready handshake. Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal.

Parameters:
STATE_W, 4, width of the state register and the debug state port.

Ports:
clk  input  1  core clock, rising-edge.
rst  input  1  synchronous, active-low reset.
op  input  7  instruction opcode, from IR[6:0].
funct3  input  3  instruction funct3.
funct7  input  1  instruction bit 30.
Zero  input  1  ALU zero flag.
mem_ready  input  1  memory port has completed the current access this cycle.
PCWrite  output  1  PC register enable.
AdrSrc  output  1  memory address select: 0 = PC, 1 = Result.
MemWrite  output  1  memory write strobe.
IRWrite  output  1  instruction and OldPC register enable.
RegWrite  output  1  register file write enable.
ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
ALUSrcB  output  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
instr_done  output  1  one-cycle pulse on the last cycle of each instruction.
illegal  output  1  sticky flag: an unsupported opcode was decoded.
state_o  output  STATE_W  current state, for debug.

Behaviour:
- Reset: a rising edge of clk with rst=0 forces the state to FETCH and clears illegal. While rst=0, PCWrite, IRWrite, RegWrite, MemWrite and instr_done are forced to 0. rst dropped mid-instruction abandons that instruction with no further write strobes.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- Output defaults in every state: enables 0, selects 00, internal ALUOp=00. Each state below lists only the outputs that differ.
- FETCH: ALUSrcB=10, ResultSrc=10, PCUpdate=1, IRWrite=mem_ready. Stays in FETCH while mem_ready=0. Goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10; this precomputes the branch target. Next state by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BEQ.
  - 1101111 -> JAL.
  - any other op -> TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01. ImmSrc=01 if op[5]=1, else 00. Next is MEMWRITE if op[5]=1, else MEMREAD.
- MEMREAD: AdrSrc=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Next is FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held asserted until mem_ready=1. On that cycle instr_done=1 and next is FETCH.
- EXECR: ALUSrcA=10, ALUOp=10. Next is ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next is ALUWB.
- ALUWB: RegWrite=1, instr_done=1. Next is FETCH.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1, instr_done=1. Next is FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1, ImmSrc=11. Next is ALUWB.
- TRAP: illegal=1, all enables 0. Stays in TRAP until reset.
- Combinational terms: PCWrite = PCUpdate | (Branch & Zero). In FETCH, PCUpdate is qualified by mem_ready.
- ALU decode:
  - ALUOp=00 -> add.
  - ALUOp=01 -> sub.
  - ALUOp=10 by funct3:
    - 000 -> sub if op[5]&funct7, else add.
    - 010 -> slt.
    - 110 -> or.
    - 111 -> and.
    - others -> add.
- Latency with mem_ready tied to 1: lw 5 cycles, sw 4, R 4, I 4, jal 4, beq 3.

Test Plan:
- Reset: hold rst=0 for 2 cycles with op=0110011 -> state_o=0, all enables 0. Release -> FETCH asserts IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
- lw (op=0000011), mem_ready=1 -> states 0,1,2,3,4. RegWrite=1 and ResultSrc=01 only in cycle 5, with instr_done=1 there. Repeat with mem_ready=0 for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, no RegWrite until MEMWB.
- sw (op=0100011) with mem_ready low for 2 cycles -> MEMWRITE=1 for 3 consecutive cycles, ImmSrc=01 in MEMADR, then FETCH. Stall in FETCH -> IRWrite=0 and PCWrite=0 until mem_ready=1.
- R-type sub (op=0110011, funct3=000, funct7=1) -> ALUControl=001 in EXECR. Same with funct7=0 -> 000. funct3=010 -> 101, funct3=111 -> 010. I-type addi with funct7=1 -> 000.
- beq with Zero=1 -> PCWrite=1 in BEQ. beq with Zero=0 -> PCWrite=0. 3-cycle instruction either way. jal -> PCWrite=1 in JAL, then ALUWB RegWrite=1.
- op=1111111 -> TRAP after DECODE, illegal=1 sticky over 10 cycles, no enables. Then rst=0 for one edge -> illegal=0, FETCH.
